// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between operand-producing logic and the bit-serial adder.
// The master drives operands and start; the slave returns status and the sum.
interface serial_add_ctrl_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         cout;
    logic         v;

    modport master (
        output start, x, y, cin,
        input  busy, done, s, cout, v
    );

    modport slave (
        input  start, x, y, cin,
        output busy, done, s, cout, v
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell steps through N bits LSB first,
// carry held in a flop, returning sum, carry-out and signed overflow.
module fulladd (
    input  logic cin,
    input  logic x,
    input  logic y,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_ctrl_if.slave     bus
);
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   xreg;
    logic [N-1:0]   yreg;
    logic [N-1:0]   sreg;
    logic           carry;
    logic [CW-1:0]  count;
    logic           cout_q;
    logic           v_q;
    logic           busy_q;
    logic           done_q;
    logic           cell_s;
    logic           cell_cout;
    logic           last_bit;

    fulladd u_fulladd (
        .cin  (carry),
        .x    (xreg[0]),
        .y    (yreg[0]),
        .s    (cell_s),
        .cout (cell_cout)
    );

    assign last_bit = (count == CW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ADD;
            ADD:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered status; carry flop holds carry into the current bit,
    // so on the last bit it is exactly the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            xreg   <= '0;
            yreg   <= '0;
            sreg   <= '0;
            carry  <= 1'b0;
            count  <= '0;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == ADD);
            done_q <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        xreg  <= bus.x;
                        yreg  <= bus.y;
                        carry <= bus.cin;
                        count <= '0;
                    end
                end
                ADD: begin
                    sreg  <= N'({cell_s, sreg} >> 1);
                    xreg  <= xreg >> 1;
                    yreg  <= yreg >> 1;
                    carry <= cell_cout;
                    count <= count + CW'(1);
                    if (last_bit) begin
                        cout_q <= cell_cout;
                        v_q    <= carry ^ cell_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = sreg;
    assign bus.cout = cout_q;
    assign bus.v    = v_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: N=8 and N=1 instances sharing clock and reset.
module tb_serial_add_ctrl;
    logic clk;
    logic rst;

    serial_add_ctrl_if #(.N(8)) bus8 ();
    serial_add_ctrl_if #(.N(1)) bus1 ();

    serial_add_ctrl #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_add_ctrl #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       cin;
        logic [7:0] s;
        logic       cout;
        logic       v;
    } vec8_t;

    typedef struct {
        logic cin;
        logic x;
        logic y;
        logic s;
        logic cout;
        logic v;
    } vec1_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op8(input vec8_t v, input string tag);
        int cyc;
        bus8.x     = v.x;
        bus8.y     = v.y;
        bus8.cin   = v.cin;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.x     = ~v.x;
        bus8.y     = ~v.y;
        bus8.cin   = ~v.cin;
        check({tag, " busy"}, 32'(bus8.busy), 32'd1);
        cyc = 1;
        while (!bus8.done && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd9);
        check({tag, " s"},    32'(bus8.s),    32'(v.s));
        check({tag, " cout"}, 32'(bus8.cout), 32'(v.cout));
        check({tag, " v"},    32'(bus8.v),    32'(v.v));
        tick();
        check({tag, " done one cycle"}, 32'({bus8.done, bus8.busy}), 32'd0);
    endtask

    task automatic run_op1(input vec1_t v, input string tag);
        int cyc;
        bus1.x     = v.x;
        bus1.y     = v.y;
        bus1.cin   = v.cin;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        cyc = 1;
        while (!bus1.done && cyc < 10) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd2);
        check({tag, " cout,s,v"}, 32'({bus1.cout, bus1.s, bus1.v}), 32'({v.cout, v.s, v.v}));
        tick();
        check({tag, " done one cycle"}, 32'(bus1.done), 32'd0);
    endtask

    vec8_t t8[8];
    vec1_t t1[8];

    initial begin
        int cyc;

        t8[0] = '{x: 8'hFF, y: 8'h01, cin: 1'b0, s: 8'h00, cout: 1'b1, v: 1'b0};
        t8[1] = '{x: 8'h7F, y: 8'h01, cin: 1'b0, s: 8'h80, cout: 1'b0, v: 1'b1};
        t8[2] = '{x: 8'hAA, y: 8'h55, cin: 1'b1, s: 8'h00, cout: 1'b1, v: 1'b0};
        t8[3] = '{x: 8'h12, y: 8'h34, cin: 1'b0, s: 8'h46, cout: 1'b0, v: 1'b0};
        t8[4] = '{x: 8'h80, y: 8'h80, cin: 1'b0, s: 8'h00, cout: 1'b1, v: 1'b1};
        t8[5] = '{x: 8'hFF, y: 8'hFF, cin: 1'b1, s: 8'hFF, cout: 1'b1, v: 1'b0};
        t8[6] = '{x: 8'h40, y: 8'h40, cin: 1'b0, s: 8'h80, cout: 1'b0, v: 1'b1};
        t8[7] = '{x: 8'h80, y: 8'h7F, cin: 1'b0, s: 8'hFF, cout: 1'b0, v: 1'b0};

        t1[0] = '{cin: 1'b0, x: 1'b0, y: 1'b0, s: 1'b0, cout: 1'b0, v: 1'b0};
        t1[1] = '{cin: 1'b0, x: 1'b0, y: 1'b1, s: 1'b1, cout: 1'b0, v: 1'b0};
        t1[2] = '{cin: 1'b0, x: 1'b1, y: 1'b0, s: 1'b1, cout: 1'b0, v: 1'b0};
        t1[3] = '{cin: 1'b0, x: 1'b1, y: 1'b1, s: 1'b0, cout: 1'b1, v: 1'b1};
        t1[4] = '{cin: 1'b1, x: 1'b0, y: 1'b0, s: 1'b1, cout: 1'b0, v: 1'b1};
        t1[5] = '{cin: 1'b1, x: 1'b0, y: 1'b1, s: 1'b0, cout: 1'b1, v: 1'b0};
        t1[6] = '{cin: 1'b1, x: 1'b1, y: 1'b0, s: 1'b0, cout: 1'b1, v: 1'b0};
        t1[7] = '{cin: 1'b1, x: 1'b1, y: 1'b1, s: 1'b1, cout: 1'b1, v: 1'b0};

        bus8.start = 1'b0; bus8.x = '0; bus8.y = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.x = '0; bus1.y = '0; bus1.cin = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset: nothing moves for 10 cycles
        for (int i = 0; i < 10; i++) begin
            check($sformatf("idle cycle %0d", i),
                  32'({bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.v}), 32'd0);
            tick();
        end

        for (int i = 0; i < 8; i++) run_op8(t8[i], $sformatf("vec8[%0d]", i));

        // Start held high across two operations; second accepted only from IDLE
        bus8.x = 8'h12; bus8.y = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.x = 8'h80; bus8.y = 8'h80; bus8.cin = 1'b0;
        cyc = 1;
        while (!bus8.done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("held first latency", 32'(cyc), 32'd9);
        check("held first result", 32'({bus8.cout, bus8.v, bus8.s}), 32'({1'b0, 1'b0, 8'h46}));
        tick();
        check("held cycle10 idle", 32'({bus8.busy, bus8.done}), 32'd0);
        check("held cycle10 s stable", 32'(bus8.s), 32'h46);
        tick();
        check("held cycle11 busy", 32'(bus8.busy), 32'd1);
        cyc = 11;
        while (!bus8.done && cyc < 40) begin
            tick();
            cyc++;
        end
        bus8.start = 1'b0;
        check("held second done cycle", 32'(cyc), 32'd19);
        check("held second result", 32'({bus8.cout, bus8.v, bus8.s}), 32'({1'b1, 1'b1, 8'h00}));
        tick();

        // Reset mid-ADD of 0xF0+0x0F
        bus8.x = 8'hF0; bus8.y = 8'h0F; bus8.cin = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset outputs", 32'({bus8.busy, bus8.done, bus8.s, bus8.cout, bus8.v}), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("mid reset stays idle", 32'({bus8.busy, bus8.done}), 32'd0);
        run_op8('{x: 8'h01, y: 8'h01, cin: 1'b0, s: 8'h02, cout: 1'b0, v: 1'b0}, "post reset");

        for (int i = 0; i < 8; i++) run_op1(t1[i], $sformatf("vec1[%0d]", i));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer that time-shares a single `fulladd` cell to add two N-bit operands, one bit per clock, LSB first. It loads the operands on a Start handshake, steps the shared full-adder through every bit position while holding the carry in a flip-flop, and returns the N-bit sum, carry-out and signed-overflow flag with a one-cycle Done strobe. It sits between operand-producing logic and the existing `fulladd` cell and replaces an N-cell ripple chain where area matters more than latency.

## Interface
- N, 8, operand/sum width in bits (legal range 1..32)
- Clock  input  1  single clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; clears all state on the edge where it is sampled high
- Start  input  1  request; sampled only in IDLE
- X  input  N  operand X, captured on the accepting edge
- Y  input  N  operand Y, captured on the accepting edge
- Cin  input  1  carry into bit 0, captured on the accepting edge
- Busy  output  1  high while bits are being processed (ADD state)
- Done  output  1  one-cycle strobe: S/Cout/V valid
- S  output  N  registered sum
- Cout  output  1  registered carry out of bit N-1
- V  output  1  registered signed overflow = carry into bit N-1 XOR carry out of bit N-1

## Operation
- Exactly one `fulladd` instance, ports in order (Cin, x, y, s, Cout); driven by carry FF, X shift-reg bit 0, Y shift-reg bit 0.
- State machine: IDLE, ADD, DONE. Encoding is free; no illegal state may persist more than one cycle (default branch returns to IDLE).
- IDLE: Start=1 -> load Xreg<=X, Yreg<=Y, carry<=Cin, count<=0; go to ADD. Start=0 -> stay. S/Cout/V keep last result.
- ADD: each edge: S shifts right with cell sum bit entering at S[N-1]; Xreg, Yreg shift right; carry<=cell Cout; count<=count+1. When count=N-2, latch the cell Cin as carry into MSB (for N=1 this is Cin itself). On the edge where count=N-1: Cout<=cell Cout, V<=cell Cin XOR cell Cout; go to DONE.
- DONE: Done=1 for exactly this cycle; next edge -> IDLE unconditionally.
- Start while in ADD or DONE is ignored (not queued); result unaffected.
- Counter width ceil(log2(N))+1 bits; no wrap issue since it resets on each load.
- Reset (any state, including mid-ADD): state<=IDLE, S<=0, Cout<=0, V<=0, carry<=0, count<=0, shift regs<=0. Reset wins over Start in the same cycle.
- Arithmetic: {Cout,S} = X + Y + Cin exactly, unsigned, modulo 2^(N+1).

## Timing
- Reset values: Busy=0, Done=0, S=0, Cout=0, V=0.
- Busy and Done decoded from state register only (no combinational path from inputs).
- Start high in cycle 0 (IDLE) -> Busy=1 cycles 1..N -> Done=1 cycle N+1 -> IDLE cycle N+2, can accept Start in cycle N+2.
- Throughput: one addition per N+2 cycles with Start held high continuously.
- S is partial during ADD; valid from Done cycle and held stable until the next accepted Start's first ADD edge.
- X, Y, Cin may change freely after the accepting edge.

## Test plan
- Reset then idle, N=8: all outputs 0 for 10 cycles with Start=0; Busy never rises.
- X=0xFF, Y=0x01, Cin=0 -> Done in cycle 9, S=0x00, Cout=1, V=0; Done high exactly one cycle.
- X=0x7F, Y=0x01, Cin=0 -> S=0x80, Cout=0, V=1; then X=0xAA, Y=0x55, Cin=1 -> S=0x00, Cout=1, V=0.
- Start held high across two operations (0x12+0x34, then 0x80+0x80 Cin=0) -> second Start accepted only in cycle 10; results S=0x46/Cout=0/V=0, then S=0x00/Cout=1/V=1; Start pulses in ADD/DONE ignored.
- Reset asserted in cycle 4 of 0xF0+0x0F -> next cycle IDLE, S=0, Cout=0, Busy=0; fresh Start 0x01+0x01 -> S=0x02, Cout=0.
- N=1, all 8 (Cin,x,y) combinations -> {Cout,S} matches full-adder truth table (000->00, 001->01, 011->10, 111->11, etc.), Done in cycle 2 each time.
